// File: rtl/cp0_pkg.sv
// Shared constants and types for the coprocessor-0 interrupt controller.
package cp0_pkg;

  localparam int unsigned XLEN    = 32;
  localparam int unsigned REG_W   = 5;
  localparam int unsigned NUM_EXT = 5;
  localparam int unsigned HOLD_W  = 4;

  localparam logic [REG_W-1:0] REG_COUNT   = 5'd9;
  localparam logic [REG_W-1:0] REG_COMPARE = 5'd11;
  localparam logic [REG_W-1:0] REG_STATUS  = 5'd12;
  localparam logic [REG_W-1:0] REG_CAUSE   = 5'd13;
  localparam logic [REG_W-1:0] REG_EPC     = 5'd14;

  localparam int unsigned IE_BIT   = 0;
  localparam int unsigned IP_LO    = 10;
  localparam int unsigned IP_HI    = 15;
  localparam int unsigned IP_W     = IP_HI - IP_LO + 1;
  localparam int unsigned TIMER_IP = 15;

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_HOLD = 1'b1
  } irq_state_e;

endpackage

// File: rtl/irq_sync.sv
// One-bit 2-flop synchronizer with a rising-edge pulse on the synchronized level.
module irq_sync (
  input  logic clk,
  input  logic rst,
  input  logic async_i,
  output logic rise_c_o
);

  logic       meta_q;
  logic       sync_q;
  logic       prev_q;
  logic [1:0] arm_q;

  // prev_q reads as high until real samples reach sync_q, so a level held
  // through reset is not mistaken for a fresh edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
      prev_q <= 1'b1;
      arm_q  <= 2'b00;
    end else begin
      meta_q <= async_i;
      sync_q <= meta_q;
      arm_q  <= {arm_q[0], 1'b1};
      prev_q <= arm_q[1] ? sync_q : 1'b1;
    end
  end

  assign rise_c_o = sync_q & ~prev_q;

endmodule

// File: rtl/irq_ctrl.sv
// CP0 interrupt controller: Count/Compare/Status/Cause/EPC, pending-interrupt
// latching and the take decision with a post-enable holdoff window.
module irq_ctrl
  import cp0_pkg::*;
#(
  parameter logic [XLEN-1:0] ISR_VECTOR = 32'hC000_0000,
  parameter int unsigned     HOLDOFF    = 3
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [REG_W-1:0]   cp0_addr,
  input  logic               cp0_we,
  input  logic [XLEN-1:0]    cp0_wdata,
  output logic [XLEN-1:0]    cp0_rdata,
  input  logic [NUM_EXT-1:0] ext_irq,
  input  logic               irq_ok,
  input  logic [XLEN-1:0]    pc_commit,
  output logic               irq_take,
  output logic [XLEN-1:0]    irq_vector
);

  logic [XLEN-1:0]    count_q, count_d;
  logic [XLEN-1:0]    compare_q, compare_d;
  logic [XLEN-1:0]    epc_q, epc_d;
  logic               ie_q, ie_d;
  logic [IP_W-1:0]    im_q, im_d;
  logic [IP_W-1:0]    ip_q, ip_d;
  logic [IP_W-1:0]    ip_set;
  logic [HOLD_W-1:0]  hold_q, hold_d;
  irq_state_e         state_q, state_d;
  logic [NUM_EXT-1:0] ext_rise;
  logic               take;
  logic               wr;
  logic               wr_status;

  for (genvar i = 0; i < NUM_EXT; i++) begin : g_sync
    irq_sync u_sync (
      .clk      (clk),
      .rst      (rst),
      .async_i  (ext_irq[i]),
      .rise_c_o (ext_rise[i])
    );
  end

  assign take       = ie_q & (|(ip_q & im_q)) & irq_ok & (state_q == ST_RUN);
  assign irq_take   = take;
  assign irq_vector = ISR_VECTOR;

  // The instruction issuing mtc0 in a take cycle is flushed, so its write is dropped.
  assign wr        = cp0_we & ~take;
  assign wr_status = wr & (cp0_addr == REG_STATUS);

  always_comb begin
    count_d   = count_q + XLEN'(1);
    compare_d = compare_q;
    epc_d     = epc_q;
    ie_d      = ie_q;
    im_d      = im_q;
    ip_d      = ip_q;
    ip_set    = '0;
    state_d   = state_q;
    hold_d    = hold_q;

    if (wr && cp0_addr == REG_COUNT)   count_d   = cp0_wdata;
    if (wr && cp0_addr == REG_COMPARE) compare_d = cp0_wdata;
    if (wr && cp0_addr == REG_EPC)     epc_d     = cp0_wdata;
    if (wr && cp0_addr == REG_CAUSE)   ip_d      = ip_q & cp0_wdata[IP_HI:IP_LO];
    if (wr_status) begin
      ie_d = cp0_wdata[IE_BIT];
      im_d = cp0_wdata[IP_HI:IP_LO];
    end

    // Hardware set events beat a same-cycle software clear.
    ip_set[NUM_EXT-1:0]     = ext_rise;
    ip_set[TIMER_IP-IP_LO]  = (count_d == compare_q);
    ip_d                    = ip_d | ip_set;

    if (take) begin
      epc_d = pc_commit;
      ie_d  = 1'b0;
    end

    unique case (state_q)
      ST_RUN: begin
        if (wr_status && !ie_q && cp0_wdata[IE_BIT]) begin
          state_d = ST_HOLD;
          hold_d  = HOLD_W'(HOLDOFF);
        end
      end
      ST_HOLD: begin
        if ((wr_status && !cp0_wdata[IE_BIT]) || hold_q <= HOLD_W'(1)) begin
          state_d = ST_RUN;
          hold_d  = '0;
        end else begin
          hold_d = hold_q - HOLD_W'(1);
        end
      end
      default: begin
        state_d = ST_RUN;
        hold_d  = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count_q   <= '0;
      compare_q <= '0;
      epc_q     <= '0;
      ie_q      <= 1'b0;
      im_q      <= '0;
      ip_q      <= '0;
      hold_q    <= '0;
      state_q   <= ST_RUN;
    end else begin
      count_q   <= count_d;
      compare_q <= compare_d;
      epc_q     <= epc_d;
      ie_q      <= ie_d;
      im_q      <= im_d;
      ip_q      <= ip_d;
      hold_q    <= hold_d;
      state_q   <= state_d;
    end
  end

  // mfc0 read mux; unmapped addresses and unused bits read 0.
  always_comb begin
    cp0_rdata = '0;
    case (cp0_addr)
      REG_COUNT:   cp0_rdata = count_q;
      REG_COMPARE: cp0_rdata = compare_q;
      REG_STATUS: begin
        cp0_rdata[IP_HI:IP_LO] = im_q;
        cp0_rdata[IE_BIT]      = ie_q;
      end
      REG_CAUSE:   cp0_rdata[IP_HI:IP_LO] = ip_q;
      REG_EPC:     cp0_rdata = epc_q;
      default:     cp0_rdata = '0;
    endcase
  end

endmodule

// File: tb/tb_irq_ctrl.sv
// Bench for irq_ctrl: directed scenarios with literal expectations, then random
// traffic checked every cycle against a rule-level model of the CP0 block.
module tb_irq_ctrl;

  localparam logic [31:0] VEC     = 32'hC000_0000;
  localparam int          HOLDOFF = 3;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [4:0]  cp0_addr = '0;
  logic        cp0_we = 1'b0;
  logic [31:0] cp0_wdata = '0;
  logic [31:0] cp0_rdata;
  logic [4:0]  ext_irq = '0;
  logic        irq_ok = 1'b0;
  logic [31:0] pc_commit = '0;
  logic        irq_take;
  logic [31:0] irq_vector;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  irq_ctrl #(.ISR_VECTOR(VEC), .HOLDOFF(HOLDOFF)) dut (
    .clk        (clk),
    .rst        (rst),
    .cp0_addr   (cp0_addr),
    .cp0_we     (cp0_we),
    .cp0_wdata  (cp0_wdata),
    .cp0_rdata  (cp0_rdata),
    .ext_irq    (ext_irq),
    .irq_ok     (irq_ok),
    .pc_commit  (pc_commit),
    .irq_take   (irq_take),
    .irq_vector (irq_vector)
  );

  // Reference model: architectural register values plus a count of cycles
  // during which takes remain blocked after IE is enabled.
  logic [31:0] m_count, m_compare, m_epc;
  logic        m_ie;
  logic [5:0]  m_im, m_ip;
  int          m_block;
  logic [4:0]  h1, h2, h3;  // ext_irq seen at the last three edges, newest first

  function automatic logic [31:0] m_read(input logic [4:0] a);
    case (a)
      5'd9:    return m_count;
      5'd11:   return m_compare;
      5'd12:   return {16'b0, m_im, 9'b0, m_ie};
      5'd13:   return {16'b0, m_ip, 10'b0};
      5'd14:   return m_epc;
      default: return 32'h0;
    endcase
  endfunction

  function automatic logic m_take();
    return m_ie && ((m_ip & m_im) != 6'b0) && irq_ok && (m_block == 0);
  endfunction

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_count = '0; m_compare = '0; m_epc = '0; m_ie = 1'b0;
      m_im = '0; m_ip = '0; m_block = 0;
      h1 = 5'h1F; h2 = 5'h1F; h3 = 5'h1F;
    end else begin
      logic        tk, w;
      logic [31:0] nc;
      logic [5:0]  set;
      tk  = m_take();
      w   = cp0_we && !tk;
      nc  = (w && cp0_addr == 5'd9) ? cp0_wdata : m_count + 32'd1;
      set = {nc == m_compare, h2 & ~h3};
      h3 = h2; h2 = h1; h1 = ext_irq;
      if (w && cp0_addr == 5'd13) m_ip = m_ip & cp0_wdata[15:10];
      m_ip = m_ip | set;
      if (m_block > 0) m_block--;
      if (w && cp0_addr == 5'd12) begin
        if (!m_ie && cp0_wdata[0]) m_block = HOLDOFF;
        else if (!cp0_wdata[0]) m_block = 0;
        m_ie = cp0_wdata[0];
        m_im = cp0_wdata[15:10];
      end
      if (w && cp0_addr == 5'd11) m_compare = cp0_wdata;
      if (w && cp0_addr == 5'd14) m_epc = cp0_wdata;
      if (tk) begin
        m_epc = pc_commit;
        m_ie  = 1'b0;
      end
      m_count = nc;
    end
  end

  always @(negedge clk) begin
    checks++;
    if (irq_take !== m_take()) begin
      errors++;
      $display("FAIL model_take t=%0t: got %b expected %b", $time, irq_take, m_take());
    end
    checks++;
    if (cp0_rdata !== m_read(cp0_addr)) begin
      errors++;
      $display("FAIL model_rdata t=%0t addr=%0d: got %h expected %h",
               $time, cp0_addr, cp0_rdata, m_read(cp0_addr));
    end
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic mtc0(input logic [4:0] a, input logic [31:0] d);
    cp0_addr = a; cp0_wdata = d; cp0_we = 1'b1;
    step();
    cp0_we = 1'b0;
  endtask

  task automatic rd(input string name, input logic [4:0] a, input logic [31:0] exp);
    cp0_addr = a;
    @(negedge clk);
    chk(name, cp0_rdata, exp);
    step();
  endtask

  task automatic tk(input string name, input logic exp);
    @(negedge clk);
    chk(name, {31'b0, irq_take}, {31'b0, exp});
    step();
  endtask

  initial begin
    // Reset with all external sources held high.
    rst = 1'b0; ext_irq = 5'h1F; irq_ok = 1'b1;
    repeat (3) step();
    rst = 1'b1;
    rd("rst_count", 5'd9, 32'h0);
    rd("rst_compare", 5'd11, 32'h0);
    rd("rst_status", 5'd12, 32'h0);
    rd("rst_cause", 5'd13, 32'h0);
    rd("rst_epc", 5'd14, 32'h0);
    repeat (4) step();
    rd("held_level_cause", 5'd13, 32'h0);
    tk("held_level_notake", 1'b0);
    chk("vector", irq_vector, 32'hC000_0000);
    ext_irq = '0;
    repeat (3) step();

    // External edge on source 4 with IM[14] and IE enabled.
    pc_commit = 32'h0040_0100;
    mtc0(5'd12, 32'h0000_4001);
    repeat (4) step();
    ext_irq[4] = 1'b1;
    tk("ext_c0", 1'b0);
    tk("ext_c1", 1'b0);
    ext_irq[4] = 1'b0;
    tk("ext_c2", 1'b0);
    tk("ext_c3_take", 1'b1);
    tk("ext_c4_once", 1'b0);
    rd("ext_epc", 5'd14, 32'h0040_0100);
    rd("ext_status", 5'd12, 32'h0000_4000);
    rd("ext_cause", 5'd13, 32'h0000_4000);

    // Timer: Count loaded to 10, Compare 20, match ten cycles later.
    mtc0(5'd13, 32'h0);
    rd("cause_cleared", 5'd13, 32'h0);
    mtc0(5'd11, 32'd20);
    mtc0(5'd12, 32'h0000_8001);
    mtc0(5'd9, 32'd10);
    for (int i = 0; i < 10; i++) tk("timer_wait", 1'b0);
    tk("timer_take", 1'b1);
    rd("timer_cause", 5'd13, 32'h0000_8000);
    mtc0(5'd13, 32'h0);
    rd("timer_cleared", 5'd13, 32'h0);
    mtc0(5'd11, 32'd50_000_020);
    rd("timer_rearm", 5'd11, 32'd50_000_020);

    // Holdoff: pending IP[11], IE enabled by mtc0.
    mtc0(5'd12, 32'h0000_0800);
    ext_irq[1] = 1'b1;
    step();
    ext_irq[1] = 1'b0;
    repeat (5) step();
    rd("pend_cause", 5'd13, 32'h0000_0800);
    mtc0(5'd12, 32'h0000_0801);
    tk("hold_c1", 1'b0);
    tk("hold_c2", 1'b0);
    tk("hold_c3", 1'b0);
    tk("hold_c4_take", 1'b1);

    // irq_ok gating, and a write dropped in the take cycle.
    irq_ok = 1'b0;
    mtc0(5'd12, 32'h0000_0801);
    for (int i = 0; i < 10; i++) tk("okgate_wait", 1'b0);
    irq_ok = 1'b1;
    cp0_addr = 5'd11; cp0_wdata = 32'h0000_1234; cp0_we = 1'b1;
    @(negedge clk);
    chk("okgate_take", {31'b0, irq_take}, 32'h1);
    step();
    cp0_we = 1'b0;
    rd("take_drops_write", 5'd11, 32'd50_000_020);
    rd("okgate_status", 5'd12, 32'h0000_0800);

    // Software clear of Cause racing a new edge on source 0.
    ext_irq[0] = 1'b1;
    step();
    step();
    mtc0(5'd13, 32'h0);
    ext_irq[0] = 1'b0;
    rd("set_beats_clear", 5'd13, 32'h0000_0400);

    // Random traffic, checked each cycle by the model.
    for (int i = 0; i < 4000; i++) begin
      irq_ok    = ($urandom_range(0, 3) != 0);
      pc_commit = $urandom;
      if ($urandom_range(0, 5) == 0) ext_irq = ext_irq ^ 5'(1 << $urandom_range(0, 4));
      cp0_we    = ($urandom_range(0, 4) == 0);
      cp0_wdata = $urandom;
      case ($urandom_range(0, 7))
        0: cp0_addr = 5'd9;
        1: cp0_addr = 5'd11;
        2, 3: cp0_addr = 5'd12;
        4: cp0_addr = 5'd13;
        5: cp0_addr = 5'd14;
        default: cp0_addr = 5'($urandom);
      endcase
      if (cp0_addr == 5'd11) cp0_wdata = m_count + 32'($urandom_range(1, 40));
      if (cp0_addr == 5'd9)  cp0_wdata = m_compare - 32'($urandom_range(1, 40));
      if ($urandom_range(0, 299) == 0) begin
        rst = 1'b0;
        step();
        rst = 1'b1;
      end
      step();
    end
    cp0_we = 1'b0;
    step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/irq_ctrl.md
# irq_ctrl

Coprocessor-0 interrupt controller for the MIPS core. Holds Count, Compare, Status, Cause and EPC; latches timer and external interrupt events into Cause.IP; decides when the pipeline takes an interrupt. On a take it saves EPC, clears Status.IE and redirects fetch to the software ISR, which dispatches on Cause/Status and returns with `jr` to EPC.

## Interface
- `ISR_VECTOR`, 32'hC000_0000: fetch address driven on interrupt take.
- `HOLDOFF`, 3: cycles takes stay blocked after software sets Status.IE 0->1 (covers the return `jr` and its delay slot).
- `clk`  in  1  core clock.
- `rst`  in  1  asynchronous, active-low reset (0 = reset).
- `cp0_addr`  in  5  CP0 register number for mfc0/mtc0.
- `cp0_we`  in  1  mtc0 write strobe.
- `cp0_wdata`  in  32  mtc0 data.
- `cp0_rdata`  out  32  mfc0 data, combinational from `cp0_addr`.
- `ext_irq`  in  5  asynchronous level sources, mapped to Cause.IP[14:10].
- `irq_ok`  in  1  pipeline at an interruptible boundary (no stall, not a delay slot).
- `pc_commit`  in  32  restart PC of the instruction being replaced.
- `irq_take`  out  1  take pulse; pipeline flushes and fetches `irq_vector`.
- `irq_vector`  out  32  constant `ISR_VECTOR`.

## Operation
- Registers: Count $9, Compare $11, Status $12 (IE bit 0, IM[15:10]), Cause $13 (IP[15:10]), EPC $14. Other addresses read 0; writes to them ignored. Unused bits read 0.
- Count increments by 1 every cycle, wraps 32'hFFFF_FFFF -> 0; mtc0 to $9 loads it (written value wins over increment).
- Timer: IP[15] sets in the cycle Count's next value equals Compare (edge, not level).
- External: each `ext_irq` bit goes through a 2-flop synchronizer and rising-edge detector; an edge sets its IP bit.
- Cause writes: software may only clear IP bits (write 0 clears, write 1 ignored). Same-cycle set event and clear: set wins.
- Take condition: Status.IE & |(IP & IM) & `irq_ok` & state RUN & no holdoff. `irq_take` is combinational from this.
- On take edge: EPC <= `pc_commit`, IE <= 0; IP and IM unchanged. Any `cp0_we` in the take cycle is dropped (instruction flushed).
- No hardware priority; software dispatches on IP & IM.
- FSM: RUN -> (mtc0 Status with IE 0->1) -> HOLD, counter loaded with HOLDOFF; HOLD decrements each cycle, -> RUN when it reaches 1. Takes blocked in HOLD. A write clearing IE in HOLD returns to RUN.

## Timing
- Reset (async assert, sync release): Count=0, Compare=0, Status=0, Cause=0, EPC=0, synchronizers=0, FSM=RUN, `irq_take`=0. First timer match therefore after 2^32 cycles unless Compare written.
- `ext_irq` rising edge to IP set: 3 clock edges; to earliest `irq_take`: same cycle IP is visible.
- Timer: IP[15] readable the cycle after Count reads Compare-1.
- mtc0 effects visible to mfc0 and take logic the following cycle.
- `irq_take` is at most one cycle wide (IE cleared at the same edge).
- Reset mid-HOLD or mid-take: all state returns to reset values immediately.

## Structure
- Package `cp0_pkg`: register numbers (9, 11, 12, 13, 14), IE bit index, IP/IM field bounds [15:10], timer IP bit 15, FSM state enum.
- Sub-module `irq_sync`: one-bit 2-flop synchronizer plus rising-edge pulse, instantiated 5 times.

## Test plan
- Reset with `ext_irq`=5'h1F held: after release all regs read 0, no take; first take needs a new edge.
- Status=0x0000_4001, pulse `ext_irq[4]`, `irq_ok`=1, `pc_commit`=0x0040_0100 -> IP[14]=1 after 3 edges, one-cycle `irq_take`, EPC=0x0040_0100, Status=0x0000_4000.
- Compare=20, Count=10, IM[15]=1, IE=1 -> IP[15] set as Count reaches 20; take; mtc0 Cause 0 clears IP[15]; Compare+50000000 rearms.
- IP pending, IE set via mtc0 -> no take for 3 cycles even with `irq_ok`=1; take on 4th.
- Pending take with `irq_ok`=0 for 10 cycles -> no take; take the cycle `irq_ok` rises; simultaneous `cp0_we` to Compare dropped.
- Software clears IP[10] in same cycle as new `ext_irq[0]` edge -> IP[10] stays 1.
